// File: rtl/aux_mem_arbiter.sv
// Purpose: shares the aux memory port between the BIST (port 0) and scan/host (port 1) requesters; round-robin with a burst lock, or strict port-0 priority with AUX_ARB_FIXED_PRIO_EN.
// Latency: grant is combinational in the request cycle; read data is valid one cycle after its grant.
// Backpressure: a requester holds req/we/addr/wdata until it sees gnt; each gnt cycle retires one access.
module aux_mem_arbiter #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P0   = 2'd1;
  localparam logic [1:0] OWN_P1   = 2'd2;

  localparam logic LAST_P0 = 1'b0;
  localparam logic LAST_P1 = 1'b1;

  logic [1:0]    owner;
  logic [CW-1:0] cnt;
  logic          last;
  logic [1:0]    rd_tag;
  logic          win0;
  logic          win1;
  logic [1:0]    win_owner;

`ifdef AUX_ARB_FIXED_PRIO_EN
  // Strict priority: port 0 always wins; nothing is granted while in reset.
  always_comb begin
    win0 = rst & req0;
    win1 = rst & req1 & ~req0;
  end
`else
  logic lock_ok;

  // Round-robin winner: the owner keeps the port under contention until its burst is used up.
  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    lock_ok = (cnt < CNT_MAX);
    if (rst) begin
      if (req0 && !req1) begin
        win0 = 1'b1;
      end else if (req1 && !req0) begin
        win1 = 1'b1;
      end else if (req0 && req1) begin
        if (owner == OWN_P0 && lock_ok) begin
          win0 = 1'b1;
        end else if (owner == OWN_P1 && lock_ok) begin
          win1 = 1'b1;
        end else if (last == LAST_P1) begin
          win0 = 1'b1;
        end else begin
          win1 = 1'b1;
        end
      end
    end
  end
`endif

  // Owner encoding of this cycle's winner (only meaningful when someone wins).
  always_comb begin
    win_owner = win0 ? OWN_P0 : OWN_P1;
  end

  // Drive the memory from the winner; park the bus at zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (win0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (win1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Ownership and burst tracking; idle cycles release ownership but keep last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
      cnt   <= '0;
      last  <= LAST_P1;
    end else if (!win0 && !win1) begin
      owner <= OWN_NONE;
      cnt   <= '0;
`ifdef AUX_ARB_FIXED_PRIO_EN
    end else begin
      owner <= win_owner;
`else
    end else if (win_owner == owner) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      owner <= win_owner;
      cnt   <= CW'(1);
      last  <= win1;
`endif
    end
  end

  // Tag granted reads so the returning data is qualified for the right port next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag <= 2'b00;
    end else begin
      rd_tag <= {win1 & ~we1, win0 & ~we0};
    end
  end

  assign gnt0    = win0;
  assign gnt1    = win1;
  assign busy    = win0 | win1;
  assign rvalid0 = rd_tag[0];
  assign rvalid1 = rd_tag[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule
